// File: rtl/cmac_link_manager.sv
// -----------------------------------------------------------------------------
// cmac_link_manager
//   Supervises one CMAC RX path. It pulses gtwiz_reset_rx_datapath, waits for
//   PCS alignment with a timeout, debounces alignment before declaring the link
//   up, and backs off exponentially after failed attempts. A change of the
//   requested RS-FEC mode or a software request forces a relink. Saturating
//   statistics are exported for a status register block.
//
// Ports
//   rx_clk            : clock (all logic in this domain)
//   rx_reset          : synchronous active-high reset
//   stat_rx_aligned   : CMAC PCS alignment (asynchronous, synchronised here)
//   rsfec_enable      : requested RS-FEC mode (asynchronous, synchronised here)
//   relink_req        : single-cycle pulse forcing a relink
//   reset_rx_datapath : to CMAC gtwiz_reset_rx_datapath
//   ctl_tx_enable     : high only in UP; ctl_tx_send_rfi is its inverse
//   ctl_*rsfec*       : latched RS-FEC mode
//   link_up           : same as ctl_tx_enable
//   fsm_state         : RESET=0 WAIT_ALIGN=1 DEBOUNCE=2 UP=3 BACKOFF=4
//   link_up_count, link_down_count, timeout_count : saturating statistics
// -----------------------------------------------------------------------------
module cmac_link_manager #(
  parameter int unsigned RESET_CYCLES      = 50,
  parameter int unsigned ALIGN_TIMEOUT     = 644531250,
  parameter int unsigned STABLE_CYCLES     = 1024,
  parameter int unsigned BACKOFF_BASE      = 32226562,
  parameter int unsigned MAX_BACKOFF_SHIFT = 4,
  parameter int unsigned CNT_W             = 16,
  parameter int unsigned SYNC_FF           = 4
) (
  input  logic             rx_clk,
  input  logic             rx_reset,
  input  logic             stat_rx_aligned,
  input  logic             rsfec_enable,
  input  logic             relink_req,
  output logic             reset_rx_datapath,
  output logic             ctl_tx_enable,
  output logic             ctl_tx_send_rfi,
  output logic             ctl_rx_rsfec_enable,
  output logic             ctl_rx_rsfec_enable_correction,
  output logic             ctl_rx_rsfec_enable_indication,
  output logic             ctl_tx_rsfec_enable,
  output logic             link_up,
  output logic [2:0]       fsm_state,
  output logic [CNT_W-1:0] link_up_count,
  output logic [CNT_W-1:0] link_down_count,
  output logic [CNT_W-1:0] timeout_count
);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_WAIT     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_UP       = 3'd3,
    ST_BACKOFF  = 3'd4
  } state_t;

  // Every timed state is loaded with its length N and leaves when the
  // counter is at 1 (or 0), so each lasts exactly N cycles.
  localparam logic [31:0] RESET_LOAD  = 32'(RESET_CYCLES);
  localparam logic [31:0] ALIGN_LOAD  = 32'(ALIGN_TIMEOUT);
  localparam logic [31:0] STABLE_LOAD = 32'(STABLE_CYCLES);
  localparam logic [39:0] BASE_WIDE   = 40'(BACKOFF_BASE);
  localparam logic [7:0]  MAX_SHIFT   = 8'(MAX_BACKOFF_SHIFT);

  // Synchronisers
  logic align_sync_reg [SYNC_FF];
  logic fec_sync_reg   [SYNC_FF];
  logic aligned_s;
  logic fec_s;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_FF; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge rx_clk) begin
          if (rx_reset) begin
            align_sync_reg[gi] <= 1'b0;
            fec_sync_reg[gi]   <= 1'b0;
          end else begin
            align_sync_reg[gi] <= stat_rx_aligned;
            fec_sync_reg[gi]   <= rsfec_enable;
          end
        end
      end else begin : g_rest
        always_ff @(posedge rx_clk) begin
          if (rx_reset) begin
            align_sync_reg[gi] <= 1'b0;
            fec_sync_reg[gi]   <= 1'b0;
          end else begin
            align_sync_reg[gi] <= align_sync_reg[gi-1];
            fec_sync_reg[gi]   <= fec_sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign aligned_s = align_sync_reg[SYNC_FF-1];
  assign fec_s     = fec_sync_reg[SYNC_FF-1];

  // State
  state_t           state_reg, state_next;
  logic [31:0]      timer_reg, timer_next;    // reset pulse / align timeout / backoff
  logic [31:0]      stable_reg, stable_next;  // debounce counter
  logic [7:0]       shift_reg, shift_next;
  logic             fec_latch_reg, fec_latch_next;
  logic [CNT_W-1:0] link_up_count_reg, link_up_count_next;
  logic [CNT_W-1:0] link_down_count_reg, link_down_count_next;
  logic [CNT_W-1:0] timeout_count_reg, timeout_count_next;
  logic             tx_enable_reg;
  logic             reset_dp_reg;

  logic [39:0] backoff_wide;
  logic [31:0] backoff_load;
  logic        go_reset;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Backoff is formed in 40 bits; anything above 32 bits saturates. Shifts
  // beyond 8 would lose bits of the 40-bit product, so they saturate too.
  always_comb begin
    backoff_wide = BASE_WIDE << shift_reg;
    backoff_load = backoff_wide[31:0];
    if ((|backoff_wide[39:32]) || ((shift_reg > 8'd8) && (BASE_WIDE != 40'd0)))
      backoff_load = 32'hFFFF_FFFF;
  end

  always_comb begin
    state_next           = state_reg;
    timer_next           = timer_reg;
    stable_next          = stable_reg;
    shift_next           = shift_reg;
    fec_latch_next       = fec_latch_reg;
    link_up_count_next   = link_up_count_reg;
    link_down_count_next = link_down_count_reg;
    timeout_count_next   = timeout_count_reg;
    go_reset             = 1'b0;

    if ((state_reg != ST_RESET) && (relink_req || (fec_s != fec_latch_reg))) begin
      // Forced relink outranks alignment loss and timeouts.
      go_reset   = 1'b1;
      shift_next = 8'd0;
      if (state_reg == ST_UP)
        link_down_count_next = sat_inc(link_down_count_reg);
    end else begin
      case (state_reg)
        ST_RESET: begin
          if (timer_reg <= 32'd1) begin
            state_next = ST_WAIT;
            timer_next = ALIGN_LOAD;
          end else begin
            timer_next = timer_reg - 32'd1;
          end
        end
        ST_WAIT: begin
          if (aligned_s) begin
            state_next  = ST_DEBOUNCE;
            stable_next = STABLE_LOAD;
          end else if (timer_reg <= 32'd1) begin
            state_next         = ST_BACKOFF;
            timer_next         = backoff_load;
            timeout_count_next = sat_inc(timeout_count_reg);
            shift_next         = (shift_reg >= MAX_SHIFT) ? MAX_SHIFT : shift_reg + 8'd1;
          end else begin
            timer_next = timer_reg - 32'd1;
          end
        end
        ST_DEBOUNCE: begin
          // The alignment timer is paused here and resumes on return.
          if (!aligned_s) begin
            state_next = ST_WAIT;
          end else if (stable_reg <= 32'd1) begin
            state_next         = ST_UP;
            shift_next         = 8'd0;
            link_up_count_next = sat_inc(link_up_count_reg);
          end else begin
            stable_next = stable_reg - 32'd1;
          end
        end
        ST_UP: begin
          if (!aligned_s) begin
            go_reset             = 1'b1;
            link_down_count_next = sat_inc(link_down_count_reg);
          end
        end
        ST_BACKOFF: begin
          if (timer_reg <= 32'd1) go_reset = 1'b1;
          else                    timer_next = timer_reg - 32'd1;
        end
        default: go_reset = 1'b1;
      endcase
    end

    if (go_reset) begin
      state_next     = ST_RESET;
      timer_next     = RESET_LOAD;
      fec_latch_next = fec_s;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_reg           <= ST_RESET;
      timer_reg           <= RESET_LOAD;
      stable_reg          <= 32'd0;
      shift_reg           <= 8'd0;
      fec_latch_reg       <= 1'b0;
      link_up_count_reg   <= '0;
      link_down_count_reg <= '0;
      timeout_count_reg   <= '0;
      tx_enable_reg       <= 1'b0;
      reset_dp_reg        <= 1'b1;
    end else begin
      state_reg           <= state_next;
      timer_reg           <= timer_next;
      stable_reg          <= stable_next;
      shift_reg           <= shift_next;
      fec_latch_reg       <= fec_latch_next;
      link_up_count_reg   <= link_up_count_next;
      link_down_count_reg <= link_down_count_next;
      timeout_count_reg   <= timeout_count_next;
      tx_enable_reg       <= (state_next == ST_UP);
      reset_dp_reg        <= (state_next == ST_RESET);
    end
  end

  // rx_reset reaches the datapath reset directly so it is held from the
  // first cycle of an external reset.
  assign reset_rx_datapath              = reset_dp_reg | rx_reset;
  assign ctl_tx_enable                  = tx_enable_reg;
  assign ctl_tx_send_rfi                = ~tx_enable_reg;
  assign link_up                        = tx_enable_reg;
  assign ctl_rx_rsfec_enable            = fec_latch_reg;
  assign ctl_rx_rsfec_enable_correction = fec_latch_reg;
  assign ctl_rx_rsfec_enable_indication = fec_latch_reg;
  assign ctl_tx_rsfec_enable            = fec_latch_reg;
  assign fsm_state                      = state_reg;
  assign link_up_count                  = link_up_count_reg;
  assign link_down_count                = link_down_count_reg;
  assign timeout_count                  = timeout_count_reg;

endmodule

// File: tb/tb_cmac_link_manager.sv
// -----------------------------------------------------------------------------
// tb_cmac_link_manager
//   Scenario tasks drive the link manager with small timing parameters. Each
//   task pushes the values it expects into a queue when it drives stimulus and
//   pops them when the corresponding DUT behaviour (a state duration or a
//   counter value) is observed. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cmac_link_manager;

  localparam int RC = 5;
  localparam int AT = 100;
  localparam int SC = 8;
  localparam int BB = 10;
  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        rx_reset = 1'b1;
  logic        stat_rx_aligned = 1'b0;
  logic        rsfec_enable = 1'b0;
  logic        relink_req = 1'b0;
  logic        reset_rx_datapath;
  logic        ctl_tx_enable;
  logic        ctl_tx_send_rfi;
  logic        ctl_rx_rsfec_enable;
  logic        ctl_rx_rsfec_enable_correction;
  logic        ctl_rx_rsfec_enable_indication;
  logic        ctl_tx_rsfec_enable;
  logic        link_up;
  logic [2:0]  fsm_state;
  logic [15:0] link_up_count;
  logic [15:0] link_down_count;
  logic [15:0] timeout_count;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int exp_up = 0;
  int exp_down = 0;
  int exp_to = 0;

  cmac_link_manager #(
    .RESET_CYCLES(RC), .ALIGN_TIMEOUT(AT), .STABLE_CYCLES(SC),
    .BACKOFF_BASE(BB), .MAX_BACKOFF_SHIFT(MS), .CNT_W(16), .SYNC_FF(4)
  ) dut (
    .rx_clk(clk),
    .rx_reset(rx_reset),
    .stat_rx_aligned(stat_rx_aligned),
    .rsfec_enable(rsfec_enable),
    .relink_req(relink_req),
    .reset_rx_datapath(reset_rx_datapath),
    .ctl_tx_enable(ctl_tx_enable),
    .ctl_tx_send_rfi(ctl_tx_send_rfi),
    .ctl_rx_rsfec_enable(ctl_rx_rsfec_enable),
    .ctl_rx_rsfec_enable_correction(ctl_rx_rsfec_enable_correction),
    .ctl_rx_rsfec_enable_indication(ctl_rx_rsfec_enable_indication),
    .ctl_tx_rsfec_enable(ctl_tx_rsfec_enable),
    .link_up(link_up),
    .fsm_state(fsm_state),
    .link_up_count(link_up_count),
    .link_down_count(link_down_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    return (v > 16'hFFFF) ? 16'hFFFF : v;
  endfunction

  // Waits (sampling on falling edges) until fsm_state equals s.
  task automatic wait_for_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fsm_state === s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Counts consecutive falling-edge samples in state s, starting now.
  task automatic measure_state(input logic [2:0] s, input int budget, output int len);
    len = 0;
    while ((fsm_state === s) && (len < budget)) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int len, exp;
    rx_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (fsm_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", fsm_state); end
    checks++;
    if ({reset_rx_datapath, ctl_tx_enable, ctl_tx_send_rfi, link_up} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=1010", {reset_rx_datapath, ctl_tx_enable, ctl_tx_send_rfi, link_up});
    end
    checks++;
    if ({ctl_rx_rsfec_enable, ctl_rx_rsfec_enable_correction, ctl_rx_rsfec_enable_indication, ctl_tx_rsfec_enable} !== 4'b0000) begin
      failures++; $display("FAIL reset_fec got=%b want=0000", {ctl_rx_rsfec_enable, ctl_rx_rsfec_enable_correction, ctl_rx_rsfec_enable_indication, ctl_tx_rsfec_enable});
    end
    checks++;
    if ({link_up_count, link_down_count, timeout_count} !== 48'd0) begin
      failures++; $display("FAIL reset_counters got=%h/%h/%h want=0", link_up_count, link_down_count, timeout_count);
    end
    // Release: datapath reset must stay high for exactly RC cycles.
    rx_reset = 1'b0;
    exp_q.push_back(RC);
    len = 0;
    while ((reset_rx_datapath === 1'b1) && (len < 50)) begin
      len++;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    $display("reset pulse after release: %0d cycles", len);
    checks++;
    if (len !== exp) begin failures++; $display("FAIL reset_pulse_len got=%0d want=%0d", len, exp); end
    checks++;
    if (fsm_state !== 3'd1) begin failures++; $display("FAIL post_reset_state got=%0d want=1", fsm_state); end
  endtask

  task automatic test_timeouts();
    int len, exp, tc, bo;
    bit ok;
    exp_q.push_back(AT);
    measure_state(3'd1, 1000, len);
    exp = exp_q.pop_front();
    $display("wait_align length: %0d", len);
    checks++;
    if (len !== exp) begin failures++; $display("FAIL wait_align_len got=%0d want=%0d", len, exp); end
    bo = BB;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bo);
      exp_to = sat16(exp_to + 1);
      exp_q.push_back(exp_to);
      if (bo < (BB << MS)) bo = bo * 2;
      wait_for_state(3'd4, 400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL backoff_%0d_entry got=state%0d want=state4", i, fsm_state); end
      tc = int'(timeout_count);
      measure_state(3'd4, 1000, len);
      $display("backoff %0d: len=%0d timeout_count=%0d", i, len, tc);
      exp = exp_q.pop_front();
      checks++;
      if (len !== exp) begin failures++; $display("FAIL backoff_%0d_len got=%0d want=%0d", i, len, exp); end
      exp = exp_q.pop_front();
      checks++;
      if (tc !== exp) begin failures++; $display("FAIL timeout_count_%0d got=%0d want=%0d", i, tc, exp); end
    end
  endtask

  task automatic test_debounce();
    int len, exp;
    bit ok, saw_up, saw_deb;
    wait_for_state(3'd1, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL glitch_wait_entry got=state%0d want=state1", fsm_state); end
    stat_rx_aligned = 1'b1;
    repeat (5) @(negedge clk);
    stat_rx_aligned = 1'b0;
    saw_up = 1'b0;
    saw_deb = 1'b0;
    repeat (20) begin
      if (fsm_state === 3'd3) saw_up = 1'b1;
      if (fsm_state === 3'd2) saw_deb = 1'b1;
      @(negedge clk);
    end
    $display("glitch: saw_debounce=%0b saw_up=%0b", saw_deb, saw_up);
    checks++;
    if (saw_up !== 1'b0) begin failures++; $display("FAIL glitch_no_up got=%0b want=0", saw_up); end
    checks++;
    if (saw_deb !== 1'b1) begin failures++; $display("FAIL glitch_debounce got=%0b want=1", saw_deb); end
    checks++;
    if (fsm_state !== 3'd1) begin failures++; $display("FAIL glitch_return got=%0d want=1", fsm_state); end
    // Steady alignment.
    stat_rx_aligned = 1'b1;
    exp_q.push_back(SC);
    exp_up = sat16(exp_up + 1);
    exp_q.push_back(exp_up);
    wait_for_state(3'd2, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL debounce_entry got=state%0d want=state2", fsm_state); end
    measure_state(3'd2, 100, len);
    $display("debounce length: %0d, link_up_count=%0d", len, link_up_count);
    exp = exp_q.pop_front();
    checks++;
    if (len !== exp) begin failures++; $display("FAIL debounce_len got=%0d want=%0d", len, exp); end
    checks++;
    if (fsm_state !== 3'd3) begin failures++; $display("FAIL up_state got=%0d want=3", fsm_state); end
    exp = exp_q.pop_front();
    checks++;
    if (int'(link_up_count) !== exp) begin failures++; $display("FAIL link_up_count got=%0d want=%0d", link_up_count, exp); end
    checks++;
    if ({ctl_tx_enable, ctl_tx_send_rfi, link_up, reset_rx_datapath} !== 4'b1010) begin
      failures++; $display("FAIL up_outputs got=%b want=1010", {ctl_tx_enable, ctl_tx_send_rfi, link_up, reset_rx_datapath});
    end
  endtask

  task automatic test_link_down();
    int len, exp;
    bit ok;
    stat_rx_aligned = 1'b0;
    exp_down = sat16(exp_down + 1);
    exp_q.push_back(exp_down);
    exp_q.push_back(RC);
    exp_q.push_back(BB);
    exp_to = sat16(exp_to + 1);
    exp_q.push_back(exp_to);
    wait_for_state(3'd0, 30, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL down_entry got=state%0d want=state0", fsm_state); end
    exp = exp_q.pop_front();
    checks++;
    if (int'(link_down_count) !== exp) begin failures++; $display("FAIL link_down_count got=%0d want=%0d", link_down_count, exp); end
    checks++;
    if ({reset_rx_datapath, ctl_tx_enable} !== 2'b10) begin failures++; $display("FAIL down_outputs got=%b want=10", {reset_rx_datapath, ctl_tx_enable}); end
    measure_state(3'd0, 50, len);
    $display("relink reset pulse: %0d cycles", len);
    exp = exp_q.pop_front();
    checks++;
    if (len !== exp) begin failures++; $display("FAIL down_reset_len got=%0d want=%0d", len, exp); end
    wait_for_state(3'd4, 300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL down_backoff_entry got=state%0d want=state4", fsm_state); end
    measure_state(3'd4, 1000, len);
    $display("backoff after up: %0d cycles", len);
    exp = exp_q.pop_front();
    checks++;
    if (len !== exp) begin failures++; $display("FAIL backoff_after_up got=%0d want=%0d", len, exp); end
    exp = exp_q.pop_front();
    checks++;
    if (int'(timeout_count) !== exp) begin failures++; $display("FAIL timeout_count_5 got=%0d want=%0d", timeout_count, exp); end
  endtask

  task automatic test_fec_relink();
    int len, exp;
    bit ok;
    stat_rx_aligned = 1'b1;
    exp_up = sat16(exp_up + 1);
    exp_q.push_back(exp_up);
    wait_for_state(3'd3, 400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fec_up_entry got=state%0d want=state3", fsm_state); end
    exp = exp_q.pop_front();
    checks++;
    if (int'(link_up_count) !== exp) begin failures++; $display("FAIL link_up_count_2 got=%0d want=%0d", link_up_count, exp); end
    // FEC change and relink_req reach the FSM in the same cycle.
    rsfec_enable = 1'b1;
    exp_down = sat16(exp_down + 1);
    exp_q.push_back(exp_down);
    exp_q.push_back(RC);
    exp_q.push_back(exp_down);
    repeat (4) @(posedge clk);
    @(negedge clk);
    relink_req = 1'b1;
    @(negedge clk);
    relink_req = 1'b0;
    checks++;
    if (fsm_state !== 3'd0) begin failures++; $display("FAIL fec_relink_state got=%0d want=0", fsm_state); end
    checks++;
    if ({ctl_rx_rsfec_enable, ctl_rx_rsfec_enable_correction, ctl_rx_rsfec_enable_indication, ctl_tx_rsfec_enable} !== 4'b1111) begin
      failures++; $display("FAIL fec_latched got=%b want=1111", {ctl_rx_rsfec_enable, ctl_rx_rsfec_enable_correction, ctl_rx_rsfec_enable_indication, ctl_tx_rsfec_enable});
    end
    exp = exp_q.pop_front();
    checks++;
    if (int'(link_down_count) !== exp) begin failures++; $display("FAIL fec_down_count got=%0d want=%0d", link_down_count, exp); end
    measure_state(3'd0, 50, len);
    $display("fec relink pulse: %0d cycles, down_count=%0d", len, link_down_count);
    exp = exp_q.pop_front();
    checks++;
    if (len !== exp) begin failures++; $display("FAIL fec_reset_len got=%0d want=%0d", len, exp); end
    checks++;
    if (fsm_state !== 3'd1) begin failures++; $display("FAIL fec_after_reset got=%0d want=1", fsm_state); end
    exp = exp_q.pop_front();
    checks++;
    if (int'(link_down_count) !== exp) begin failures++; $display("FAIL fec_single_relink got=%0d want=%0d", link_down_count, exp); end
  endtask

  task automatic test_saturation();
    int exp;
    bit ok;
    exp_up = sat16(exp_up + 1);
    wait_for_state(3'd3, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL sat_up_entry got=state%0d want=state3", fsm_state); end
    @(negedge clk);
    force dut.link_up_count_next = 16'hFFFF;
    @(posedge clk);
    #1 release dut.link_up_count_next;
    exp_up = 16'hFFFF;
    @(negedge clk);
    // Cycle the link once more.
    stat_rx_aligned = 1'b0;
    exp_down = sat16(exp_down + 1);
    exp_up = sat16(exp_up + 1);
    exp_q.push_back(exp_up);
    exp_q.push_back(exp_down);
    wait_for_state(3'd0, 30, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL sat_down_entry got=state%0d want=state0", fsm_state); end
    stat_rx_aligned = 1'b1;
    @(negedge clk);
    wait_for_state(3'd3, 300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL sat_relink_up got=state%0d want=state3", fsm_state); end
    $display("saturation: link_up_count=%h link_down_count=%0d", link_up_count, link_down_count);
    exp = exp_q.pop_front();
    checks++;
    if (int'(link_up_count) !== exp) begin failures++; $display("FAIL link_up_saturate got=%h want=%h", link_up_count, exp); end
    exp = exp_q.pop_front();
    checks++;
    if (int'(link_down_count) !== exp) begin failures++; $display("FAIL sat_down_count got=%0d want=%0d", link_down_count, exp); end
  endtask

  task automatic test_reset_mid_backoff();
    bit ok;
    stat_rx_aligned = 1'b0;
    wait_for_state(3'd4, 400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midreset_backoff_entry got=state%0d want=state4", fsm_state); end
    repeat (2) @(negedge clk);
    rx_reset = 1'b1;
    exp_q.push_back(0);
    repeat (2) @(negedge clk);
    $display("reset mid-backoff: state=%0d counts=%0d/%0d/%0d", fsm_state, link_up_count, link_down_count, timeout_count);
    checks++;
    if (fsm_state !== 3'd0) begin failures++; $display("FAIL midreset_state got=%0d want=0", fsm_state); end
    checks++;
    if (int'({link_up_count, link_down_count, timeout_count}) !== exp_q.pop_front()) begin
      failures++; $display("FAIL midreset_counters got=%h/%h/%h want=0", link_up_count, link_down_count, timeout_count);
    end
    checks++;
    if ({reset_rx_datapath, ctl_tx_enable, ctl_tx_send_rfi, ctl_rx_rsfec_enable, ctl_tx_rsfec_enable} !== 5'b10100) begin
      failures++; $display("FAIL midreset_outputs got=%b want=10100", {reset_rx_datapath, ctl_tx_enable, ctl_tx_send_rfi, ctl_rx_rsfec_enable, ctl_tx_rsfec_enable});
    end
    rx_reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_timeouts();
    test_debounce();
    test_link_down();
    test_fec_relink();
    test_saturation();
    test_reset_mid_backoff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/cmac_link_manager.md
Name: cmac_link_manager

Overview:
- Parametrised successor to the CMAC control logic: supervises one CMAC RX path in the rx_clk domain.
- Drives gtwiz_reset_rx_datapath, tx enable and RFI, and the RS-FEC controls.
- Debounces PCS alignment and retries with exponential backoff.
- Forces a relink when RS-FEC mode changes or on software request.
- Exports state and saturating link statistics for a status register block.

Parameters:
RESET_CYCLES, 50, cycles reset_rx_datapath is held per reset pulse (>=1)
ALIGN_TIMEOUT, 644531250, cycles to wait for alignment after a reset pulse (2 s at 322.265625 MHz)
STABLE_CYCLES, 1024, cycles alignment must stay continuously high before the link is declared up (>=1)
BACKOFF_BASE, 32226562, base backoff in cycles after a failed alignment (100 ms)
MAX_BACKOFF_SHIFT, 4, maximum left-shift applied to BACKOFF_BASE
CNT_W, 16, width of the statistics counters
SYNC_FF, 4, synchroniser depth for stat_rx_aligned and rsfec_enable

Ports:
rx_clk  in  1  clock
rx_reset  in  1  synchronous, active-high reset
stat_rx_aligned  in  1  CMAC PCS alignment, asynchronous
rsfec_enable  in  1  requested RS-FEC mode, asynchronous
relink_req  in  1  single-cycle pulse, forces a relink
reset_rx_datapath  out  1  to CMAC gtwiz_reset_rx_datapath
ctl_tx_enable  out  1  high only in state UP
ctl_tx_send_rfi  out  1  inverse of ctl_tx_enable
ctl_rx_rsfec_enable, ctl_rx_rsfec_enable_correction, ctl_rx_rsfec_enable_indication, ctl_tx_rsfec_enable  out  1 each  latched FEC mode
link_up  out  1  same as ctl_tx_enable
fsm_state  out  3  current state encoding
link_up_count  out  CNT_W  number of transitions into UP
link_down_count  out  CNT_W  number of transitions out of UP
timeout_count  out  CNT_W  number of alignment timeouts

Behaviour:
- Synchronisers: stat_rx_aligned -> aligned_s and rsfec_enable -> fec_s, each through SYNC_FF flops. The flops clear on rx_reset.
- States and encodings:
  - RESET=0: reset_rx_datapath=1 for exactly RESET_CYCLES cycles, then go to WAIT_ALIGN and load the alignment timer with ALIGN_TIMEOUT.
  - WAIT_ALIGN=1: if aligned_s, go to DEBOUNCE and load the stable counter. Otherwise the timer decrements each cycle. When it reaches 0: increment timeout_count, go to BACKOFF, load (BACKOFF_BASE << shift), then shift = min(shift+1, MAX_BACKOFF_SHIFT).
  - DEBOUNCE=2: if aligned_s drops, return to WAIT_ALIGN. The timer continues from its current value and is not reloaded. After STABLE_CYCLES consecutive high cycles, go to UP, set shift=0, and increment link_up_count.
  - UP=3: if aligned_s drops, go to RESET and increment link_down_count.
  - BACKOFF=4: count down, then go to RESET.
- rx_reset, applied at any time including mid-state:
  - state=RESET with a fresh RESET_CYCLES pulse;
  - shift=0, all counters=0, sync flops=0;
  - FEC latch = 0;
  - reset_rx_datapath=1 while rx_reset is high;
  - ctl_tx_enable=0, ctl_tx_send_rfi=1.
- FEC latch: the latched mode drives all four ctl_*rsfec* outputs and is loaded from fec_s only on entry to RESET. If fec_s differs from the latch in any state other than RESET, go to RESET (a relink). This increments link_down_count if leaving UP and resets shift to 0.
- relink_req: in any state other than RESET, go to RESET next cycle. This increments link_down_count if leaving UP and resets shift to 0. In RESET it is ignored.
- Event priority within one cycle:
  1. rx_reset
  2. relink_req or FEC change
  3. alignment loss or timeout
  4. normal progression
- Counters saturate at all-ones and do not wrap.
- Outputs are registered; state changes are visible 1 cycle after the causing input at the synchroniser output.
- Timers are 32 bits wide. Backoff is computed in 40 bits and saturates at 2^32-1.

Test Plan:
- Use small parameters RESET_CYCLES=5, ALIGN_TIMEOUT=100, STABLE_CYCLES=8, BACKOFF_BASE=10, MAX_BACKOFF_SHIFT=2.
- Release rx_reset with aligned=0 -> reset_rx_datapath high for exactly 5 cycles after the release edge, then fsm_state=1.
- Hold aligned=0 -> timeouts every cycle of reset+100; backoff lengths 10, 20, 40, 40; timeout_count increments 1, 2, 3, 4.
- Raise aligned for 5 cycles, drop it, then raise it steadily -> no UP during the glitch; UP after 8 stable cycles; link_up_count=1; ctl_tx_enable=1; ctl_tx_send_rfi=0; next backoff after a failure is 10.
- Drop aligned while UP -> state RESET, link_down_count=1, 5-cycle reset pulse.
- In UP, toggle rsfec_enable 0->1 -> relink; ctl_*rsfec* outputs become 1 on RESET entry; relink_req the same cycle causes a single relink only.
- Saturation: preload link_up_count to all-ones (force) and cycle the link -> count stays 0xFFFF. Assert rx_reset mid-BACKOFF -> all counters 0, state RESET.
